bram_arbiter: RTL and testbench
===============================

# bram_arbiter

Controller that shares one byte-wide single-port BRAM between two requesters: the CPU data port (A: byte/half/word, 32-bit data) and the boot/debug loader port (B: byte only). It arbitrates round-robin, serialises multi-byte accesses into consecutive little-endian byte beats, and assembles read data. It sits between the core/loader and a BRAM instance with 1-cycle registered read latency, with read and write enables.

## Interface
Parameters:
- ADDR_WIDTH, 10, byte-address width of the BRAM (depth 2^ADDR_WIDTH bytes)

Ports:
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- a_req  in  1  CPU request; held until a_ack
- a_we  in  1  1=write, 0=read
- a_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- a_addr  in  ADDR_WIDTH  byte address of beat 0
- a_wdata  in  32  write data; byte k = a_wdata[8k+7:8k]
- a_ack  out  1  one-cycle completion pulse
- a_rdata  out  32  read data, valid while a_ack=1, unused upper bytes zero
- b_req  in  1  loader request; held until b_ack
- b_we  in  1  1=write, 0=read
- b_addr  in  ADDR_WIDTH  byte address
- b_wdata  in  8  write byte
- b_ack  out  1  one-cycle completion pulse
- b_rdata  out  8  read byte, valid while b_ack=1
- mem_addr  out  ADDR_WIDTH  BRAM address
- mem_wdata  out  8  BRAM write data
- mem_wen  out  1  BRAM write enable
- mem_ren  out  1  BRAM read enable
- mem_rdata  in  8  BRAM read data, valid the cycle after mem_ren

## Operation
- States: IDLE, ACCESS, FIN, ACK.
- IDLE: if any req, grant and latch we/addr/size/wdata of winner; beat count N = 1/2/4 (B always 1); go ACCESS. No req: stay.
- Arbitration: only one request -> it wins. Both -> the port not granted last; last_grant resets to B so A wins the first tie.
- ACCESS: one beat per cycle, beat k: mem_addr = addr+k (modulo 2^ADDR_WIDTH, wraps), mem_ren=~we, mem_wen=we, mem_wdata = byte k. After beat N-1: reads -> FIN, writes -> ACK.
- Read capture: mem_rdata in cycle after beat k is stored to result byte k (so beats 0..N-2 captured during ACCESS, beat N-1 in FIN).
- FIN: no BRAM enables; captures last byte; -> ACK.
- ACK: winner's ack=1 for exactly this cycle, rdata presented; -> IDLE. Requester must drop or change req after ack; a req still high in the following IDLE is a new request.
- Misaligned accesses allowed; no alignment fault.
- Result register cleared at grant, so bytes >= N read as zero.
- Outside ACCESS: mem_wen=mem_ren=0, mem_addr=0, mem_wdata=0.
- Inputs changing after grant are ignored (latched).

## Timing
- Reset values: state IDLE, a_ack=b_ack=0, a_rdata=0, b_rdata=0, mem_* outputs 0, last_grant=B.
- Req sampled in IDLE at cycle R; first beat at R+1.
- Ack cycle: byte write R+2, byte read R+3, half write R+3, half read R+4, word write R+5, word read R+6.
- Minimum gap: after ack cycle, one IDLE cycle before next grant.
- Reset asserted mid-access: immediate return to reset values; pending access abandoned, no ack; BRAM may hold partially written bytes.
- Request arriving during busy: waits, no loss, served in next IDLE by arbitration.

## Structure
- Shared package bram_arb_pkg: state encodings, size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), port IDs (GNT_A/GNT_B).
- One sub-module: bram_rr_arb, two-input round-robin picker (req_a, req_b, last_grant -> grant). Rest (FSM, beat counter, capture register) in bram_arbiter.

## Test plan
- Word write A addr 0x010 data 0xDEADBEEF, then word read -> bytes 0x10..0x13 = EF,BE,AD,DE; a_rdata=0xDEADBEEF, acks at R+5 and R+6.
- Byte read A after the above at 0x012 size 0 -> a_rdata=0x000000AD at R+3.
- Wrap: word write at 0x3FE (ADDR_WIDTH=10) data 0x44332211 -> 0x3FE=11, 0x3FF=22, 0x000=33, 0x001=44.
- Tie: a_req and b_req high together from reset, held -> A acked first, then B, then A (alternation); no cycle with both acks.
- B byte write 0x5A at 0x020 then read -> b_rdata=0x5A at R+3; a_rdata unchanged.
- Reset pulse at cycle R+3 of a word write -> no ack, all outputs 0, next request served normally from IDLE.

Source files
------------

// File: rtl/bram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_arb_pkg
// Description : Shared types and constants for the two-port byte-BRAM arbiter.
//               It holds the FSM state encoding, the access-size codes, the
//               grant IDs, and a helper that maps a size code to the index of
//               its last beat.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_FIN    = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } gnt_t;

  // Index of the final byte beat. The reserved size code 3 behaves as a word.
  function automatic logic [1:0] last_beat(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 2'd0;
      SZ_HALF: return 2'd1;
      SZ_WORD: return 2'd3;
      default: return 2'd3;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : bram_rr_arb
// Description : Two-input round-robin picker. A lone requester always wins.
//               When both ports request, the port that was not granted last
//               wins.
// Ports       : i_req_a      - request from port A
//               i_req_b      - request from port B
//               i_last_grant - port granted most recently
//               o_grant      - selected port (only meaningful if any request)
// Revision    : 1.0 - initial release
// ============================================================================
module bram_rr_arb
  import bram_arb_pkg::*;
(
  input  logic i_req_a,
  input  logic i_req_b,
  input  gnt_t i_last_grant,
  output gnt_t o_grant
);

  always_comb begin
    o_grant = GNT_A;
    if (i_req_a && i_req_b) begin
      if (i_last_grant == GNT_A) begin
        o_grant = GNT_B;
      end
    end else if (i_req_b) begin
      o_grant = GNT_B;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_arbiter
// Description : Shares one byte-wide single-port BRAM (1-cycle read latency)
//               between a CPU port (A: byte/half/word) and a loader port
//               (B: byte). Multi-byte accesses are split into little-endian
//               byte beats, and read bytes are assembled into the result.
// Ports       : clk, rst_n                    - clock, async active-low reset
//               a_req/a_we/a_size/a_addr/a_wdata - CPU request (held to ack)
//               a_ack/a_rdata                  - CPU completion pulse and data
//               b_req/b_we/b_addr/b_wdata      - loader request (held to ack)
//               b_ack/b_rdata                  - loader completion and data
//               mem_addr/mem_wdata/mem_wen/mem_ren/mem_rdata - BRAM side
// Revision    : 1.0 - initial release
// ============================================================================
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [1:0]            a_size,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [31:0]           a_wdata,
  output logic                  a_ack,
  output logic [31:0]           a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [7:0]            b_wdata,
  output logic                  b_ack,
  output logic [7:0]            b_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [7:0]            mem_rdata
);

  state_t                r_state;
  state_t                w_state_nxt;
  gnt_t                  r_gnt;
  gnt_t                  r_last_gnt;
  gnt_t                  w_gnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [1:0]            r_last_beat;
  logic [1:0]            r_beat;
  logic                  r_rd_pend;
  logic [1:0]            r_rd_idx;
  logic [31:0]           r_a_rdata;
  logic [7:0]            r_b_rdata;
  logic                  w_grant_en;
  logic                  w_beat_done;

  assign w_grant_en  = (r_state == ST_IDLE) && (a_req || b_req);
  assign w_beat_done = (r_beat == r_last_beat);

  bram_rr_arb u_arb (
    .i_req_a      (a_req),
    .i_req_b      (b_req),
    .i_last_grant (r_last_gnt),
    .o_grant      (w_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (a_req || b_req) w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (w_beat_done) begin
          if (r_we) w_state_nxt = ST_ACK;
          else      w_state_nxt = ST_FIN;
        end
      end
      ST_FIN:  w_state_nxt = ST_ACK;
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, beat counter and read-data capture. The read data of a
  // beat arrives one cycle later, so the beat index is delayed alongside a
  // pending flag. The final byte is therefore captured during FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt       <= GNT_A;
      r_last_gnt  <= GNT_B;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_last_beat <= 2'd0;
      r_beat      <= 2'd0;
      r_rd_pend   <= 1'b0;
      r_rd_idx    <= 2'd0;
      r_a_rdata   <= '0;
      r_b_rdata   <= '0;
    end else begin
      r_rd_pend <= (r_state == ST_ACCESS) && !r_we;
      r_rd_idx  <= r_beat;
      if (w_grant_en) begin
        r_gnt      <= w_gnt;
        r_last_gnt <= w_gnt;
        r_beat     <= 2'd0;
        if (w_gnt == GNT_A) begin
          r_we        <= a_we;
          r_addr      <= a_addr;
          r_wdata     <= a_wdata;
          r_last_beat <= last_beat(a_size);
          r_a_rdata   <= '0;
        end else begin
          r_we        <= b_we;
          r_addr      <= b_addr;
          r_wdata     <= {24'h0, b_wdata};
          r_last_beat <= 2'd0;
          r_b_rdata   <= '0;
        end
      end else if (r_state == ST_ACCESS) begin
        r_beat <= r_beat + 2'd1;
      end
      if (r_rd_pend) begin
        if (r_gnt == GNT_A) r_a_rdata[{r_rd_idx, 3'b000} +: 8] <= mem_rdata;
        else                r_b_rdata <= mem_rdata;
      end
    end
  end

  // BRAM drive is active only in ACCESS. The address adds the beat index and
  // wraps at the top of the BRAM.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = 8'h00;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    if (r_state == ST_ACCESS) begin
      mem_addr  = r_addr + {{(ADDR_WIDTH-2){1'b0}}, r_beat};
      mem_wdata = r_wdata[{r_beat, 3'b000} +: 8];
      mem_wen   = r_we;
      mem_ren   = !r_we;
    end
  end

  assign a_ack   = (r_state == ST_ACK) && (r_gnt == GNT_A);
  assign b_ack   = (r_state == ST_ACK) && (r_gnt == GNT_B);
  assign a_rdata = r_a_rdata;
  assign b_rdata = r_b_rdata;

endmodule
`default_nettype wire

// File: tb/tb_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_arbiter
// Description : Self-checking bench for bram_arbiter. It contains a
//               behavioural BRAM and a byte-array reference model of the
//               memory contents. Expected latency, beat addresses and read
//               data are derived from the access size and the port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_arbiter;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_we;
  logic [1:0]    a_size;
  logic [AW-1:0] a_addr;
  logic [31:0]   a_wdata;
  logic          a_ack;
  logic [31:0]   a_rdata;
  logic          b_req, b_we;
  logic [AW-1:0] b_addr;
  logic [7:0]    b_wdata;
  logic          b_ack;
  logic [7:0]    b_rdata;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_wen, mem_ren;
  logic [7:0]    mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [7:0] ref_mem [DEPTH];
  logic [7:0] bram    [DEPTH];
  bit         bram_ready = 1'b0;

  bram_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_size    (a_size),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_ack     (a_ack),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_ack     (b_ack),
    .b_rdata   (b_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen),
    .mem_ren   (mem_ren),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Byte BRAM with registered read. It is cleared on its first clock edge.
  always @(posedge clk) begin
    if (!bram_ready) begin
      for (int i = 0; i < DEPTH; i++) bram[i] <= 8'h00;
      mem_rdata  <= 8'h00;
      bram_ready <= 1'b1;
    end else begin
      if (mem_wen) bram[mem_addr] <= mem_wdata;
      if (mem_ren) mem_rdata <= bram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input bit port, input logic [1:0] size);
    if (port) return 1;
    case (size)
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on a single port (port 0 = A, port 1 = B).
  // The task starts in an IDLE cycle and returns in the following IDLE cycle.
  task automatic txn(input bit port, input bit we, input logic [1:0] size,
                     input logic [AW-1:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata);
    int          n, lat, beats, exp_lat, ea;
    bit          got;
    logic [31:0] exp_rd;
    n       = nbytes(port, size);
    exp_lat = n + (we ? 1 : 2);
    exp_rd  = '0;
    for (int k = 0; k < n; k++) exp_rd[8*k +: 8] = ref_mem[(int'(addr) + k) % DEPTH];
    if (port) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata[7:0];
    end else begin
      a_req = 1'b1; a_we = we; a_size = size; a_addr = addr; a_wdata = wdata;
    end
    got = 1'b0; lat = 0; beats = 0; rdata = '0;
    while (!got && lat < 20) begin
      tick();
      lat++;
      if (mem_wen || mem_ren) begin
        ea = (int'(addr) + beats) % DEPTH;
        chk("beat_addr", 32'(mem_addr), 32'(ea));
        chk("beat_en", 32'({mem_wen, mem_ren}), we ? 32'd2 : 32'd1);
        if (we && beats < 4) chk("beat_wdata", 32'(mem_wdata), 32'(wdata[8*beats +: 8]));
        beats++;
      end
      chk("no_stray_ack", 32'(port ? a_ack : b_ack), 32'd0);
      if (port ? b_ack : a_ack) begin
        got   = 1'b1;
        rdata = port ? {24'h0, b_rdata} : a_rdata;
        chk("ack_latency", lat, exp_lat);
        if (!we) chk("rdata", rdata, exp_rd);
        if (port) b_req = 1'b0;
        else      a_req = 1'b0;
      end
    end
    chk("ack_seen", 32'(got), 32'd1);
    a_req = 1'b0;
    b_req = 1'b0;
    chk("beat_count", beats, n);
    if (we) for (int k = 0; k < n; k++) ref_mem[(int'(addr) + k) % DEPTH] = wdata[8*k +: 8];
    tick();
    chk("idle_quiet", 32'({mem_wen, mem_ren, a_ack, b_ack}), 32'd0);
  endtask

  logic [31:0] rd;
  int          seq [3];
  int          nack, tlat;
  bit          ack_seen;
  bit          r_port, r_we;
  logic [1:0]  r_size;
  logic [AW-1:0] r_addr;

  initial begin
    rst_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_size = 2'd0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 3; i++) seq[i] = 0;

    // Reset values
    repeat (3) tick();
    chk("rst_a_ack", 32'(a_ack), 32'd0);
    chk("rst_b_ack", 32'(b_ack), 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    chk("rst_b_rdata", 32'(b_rdata), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_mem_wen", 32'(mem_wen), 32'd0);
    chk("rst_mem_ren", 32'(mem_ren), 32'd0);
    rst_n = 1'b1;
    tick();

    // Tie from reset with both requests held: the acks must alternate A, B, A
    a_req = 1'b1; a_we = 1'b0; a_size = 2'd2; a_addr = 10'h100;
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'h200;
    nack = 0; tlat = 0;
    while (nack < 3 && tlat < 60) begin
      tick();
      tlat++;
      chk("tie_no_dual_ack", 32'(a_ack & b_ack), 32'd0);
      if (a_ack || b_ack) begin
        seq[nack] = a_ack ? 1 : 2;
        if (nack == 0) chk("tie_first_lat", tlat, 6);
        nack++;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    chk("tie_ack_count", nack, 3);
    chk("tie_order0", seq[0], 1);
    chk("tie_order1", seq[1], 2);
    chk("tie_order2", seq[2], 1);
    tick();

    // Word write/read, then a misaligned byte read
    txn(1'b0, 1'b1, 2'd2, 10'h010, 32'hDEADBEEF, rd);
    txn(1'b0, 1'b0, 2'd2, 10'h010, 32'h0, rd);
    chk("word_read", rd, 32'hDEADBEEF);
    txn(1'b0, 1'b0, 2'd0, 10'h012, 32'h0, rd);
    chk("byte_read", rd, 32'h000000AD);

    // Loader byte write and read back; the CPU read data must not change
    txn(1'b1, 1'b1, 2'd0, 10'h020, 32'h5A, rd);
    txn(1'b1, 1'b0, 2'd0, 10'h020, 32'h0, rd);
    chk("b_read", rd, 32'h5A);
    chk("a_rdata_hold", a_rdata, 32'h000000AD);

    // Address wrap at the top of the BRAM
    txn(1'b0, 1'b1, 2'd2, 10'h3FE, 32'h44332211, rd);
    txn(1'b0, 1'b0, 2'd0, 10'h3FE, 32'h0, rd);
    chk("wrap_3fe", rd, 32'h11);
    txn(1'b0, 1'b0, 2'd0, 10'h3FF, 32'h0, rd);
    chk("wrap_3ff", rd, 32'h22);
    txn(1'b0, 1'b0, 2'd0, 10'h000, 32'h0, rd);
    chk("wrap_000", rd, 32'h33);
    txn(1'b0, 1'b0, 2'd1, 10'h000, 32'h0, rd);
    chk("wrap_half", rd, 32'h4433);

    // Reset asserted in cycle R+3 of a word write
    a_req = 1'b1; a_we = 1'b1; a_size = 2'd2; a_addr = 10'h050; a_wdata = 32'hCAFEF00D;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a_ack", 32'(a_ack), 32'd0);
    chk("mid_rst_a_rdata", a_rdata, 32'd0);
    chk("mid_rst_b_rdata", 32'(b_rdata), 32'd0);
    chk("mid_rst_mem", 32'({mem_addr, mem_wdata, mem_wen, mem_ren}), 32'd0);
    a_req = 1'b0;
    ack_seen = 1'b0;
    repeat (3) begin
      tick();
      if (a_ack || b_ack) ack_seen = 1'b1;
    end
    chk("mid_rst_no_ack", 32'(ack_seen), 32'd0);
    rst_n = 1'b1;
    // Beats 0 and 1 completed before the reset edge
    ref_mem[10'h050] = 8'h0D;
    ref_mem[10'h051] = 8'hF0;
    txn(1'b0, 1'b0, 2'd2, 10'h050, 32'h0, rd);
    chk("post_rst_read", rd, 32'h0000F00D);

    // Randomised single-port traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      r_port = 1'($urandom_range(0, 1));
      r_we   = 1'($urandom_range(0, 1));
      r_size = 2'($urandom_range(0, 3));
      r_addr = AW'($urandom);
      txn(r_port, r_we, r_size, r_addr, $urandom, rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
